uart_tx_engine: RTL and testbench

Parametrised UART transmit engine: accepts a parallel word on a valid/busy handshake and emits a complete serial frame on `tx_out`. Each frame is a start bit, DATA_WIDTH data bits LSB-first, an optional even/odd parity bit, and one or two stop bits. An internal prescaler sets the bit period. The block replaces the fixed 8-bit, one-bit-per-clock UART TX controller and serializer pair in the UART TX path, and feeds the pad/line driver directly.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_strobe.sv | 27 ++
 rtl/uart_tx_engine.sv | 130 +++++++++++++
 tb/tb_uart_tx_engine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// State encoding is fixed so line-side debug taps stay stable.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_baud_strobe.sv
// Bit-period prescaler: strobes on the last cycle of each bit.
// Held at zero while idle so every frame starts on a clean period.
module uart_baud_strobe #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      run,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_strobe
);

    logic [PRESCALE_WIDTH-1:0] cnt;

    assign bit_strobe = run && (cnt == prescale);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run || bit_strobe) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start, LSB-first data, optional parity, 1/2 stop.
// Frame configuration is captured on acceptance and held for the frame.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic                      stop2,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy,
    output logic                      tx_done
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    tx_state_t                 state;
    logic [DATA_WIDTH-1:0]     shreg;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic [3:0]                bit_cnt;
    logic                      par_en_q;
    logic                      par_bit_q;
    logic                      stop2_q;
    logic                      bit_strobe;

    uart_baud_strobe #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_baud (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (busy),
        .prescale  (prescale_q),
        .bit_strobe(bit_strobe)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            prescale_q <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    if (data_valid) begin
                        state      <= START;
                        busy       <= 1'b1;
                        tx_out     <= 1'b0;
                        shreg      <= p_data;
                        prescale_q <= prescale;
                        par_en_q   <= par_en;
                        par_bit_q  <= (^p_data) ^ (par_typ == PAR_ODD);
                        stop2_q    <= stop2;
                        bit_cnt    <= '0;
                    end
                end
                START: begin
                    if (bit_strobe) begin
                        state   <= DATA;
                        tx_out  <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_strobe) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_en_q) begin
                                state  <= PARITY;
                                tx_out <= par_bit_q;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= shreg >> 1;
                            tx_out  <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_strobe) begin
                        state   <= STOP;
                        tx_out  <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (bit_strobe) begin
                        if (bit_cnt == {3'b000, stop2_q}) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                            tx_out  <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    // Corrupted state: drop back to a quiet idle line.
                    state   <= IDLE;
                    bit_cnt <= '0;
                    tx_out  <= 1'b1;
                    busy    <= 1'b0;
                    tx_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine against a frame-level model.
// Expected line levels come from the frame bit list, one entry per bit.
module tb_uart_tx_engine;

    localparam int DW = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          data_valid = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          stop2 = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          tx_out;
    logic          busy;
    logic          tx_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(
        .DATA_WIDTH    (DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .stop2     (stop2),
        .prescale  (prescale),
        .tx_out    (tx_out),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_tx", {31'b0, tx_out}, 1);
            check("idle_busy", {31'b0, busy}, 0);
            check("idle_done", {31'b0, tx_done}, 0);
        end
    endtask

    // Drives a word, then checks every cycle of the resulting frame and
    // the idle/done cycle after it. Inputs are scrambled mid-frame.
    task automatic run_frame(input logic [DW-1:0] d, input logic pe,
                             input logic pt, input logic s2,
                             input int ps, input bit hold);
        logic bits[$];
        int   p;
        int   n;
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        stop2      = s2;
        prescale   = PW'(ps);
        data_valid = 1'b1;
        bits.push_back(1'b0);
        for (int b = 0; b < DW; b++) bits.push_back(d[b]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        p = ps + 1;
        n = bits.size() * p;
        @(posedge clk);
        #1;
        if (!hold) data_valid = 1'b0;
        p_data   = DW'($urandom);
        prescale = PW'($urandom_range(0, 7));
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
        stop2    = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("tx_out", {31'b0, tx_out}, {31'b0, bits[i / p]});
            check("busy", {31'b0, busy}, 1);
            check("tx_done", {31'b0, tx_done}, 0);
            if (!hold && i == n / 2) data_valid = 1'b1;
            if (!hold && i == n / 2 + 1) data_valid = 1'b0;
        end
        @(negedge clk);
        check("end_tx", {31'b0, tx_out}, 1);
        check("end_busy", {31'b0, busy}, 0);
        check("end_done", {31'b0, tx_done}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hold;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx_out}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, tx_done}, 0);
        reset_n = 1'b1;
        idle(2);

        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        idle(1);
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        idle(1);
        run_frame(8'h0F, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle(1);

        run_frame(8'h11, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        run_frame(8'h22, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        run_frame(8'h33, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        idle(2);

        // Abort a frame in the middle of a data bit.
        p_data     = 8'h3C;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        stop2      = 1'b0;
        prescale   = PW'(3);
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_rst_busy", {31'b0, busy}, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'b0, tx_out}, 1);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_done", {31'b0, tx_done}, 0);
        @(negedge clk);
        check("held_rst_tx", {31'b0, tx_out}, 1);
        check("held_rst_busy", {31'b0, busy}, 0);
        reset_n = 1'b1;
        idle(2);
        run_frame(8'hC3, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        idle(1);

        for (int k = 0; k < 20; k++) begin
            hold = (k < 19) ? 1'($urandom) : 1'b0;
            run_frame(DW'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(0, 7), hold);
            if (!hold) idle($urandom_range(0, 2));
        end
        data_valid = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
